sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Downstream partner of the PISO shift register: consumes the serial bit stream it produces and reassembles parallel words.
- Handles MSB-first or LSB-first ordering, counts bits, and presents completed words on a valid/ready output port.
- Flags overrun when a word completes while the previous word is still unconsumed.
- Sits between the serial link and any parallel consumer, such as a register file or FIFO.

Parameters:
- WIDTH, 4, word width in bits; must be ≥ 2.
- CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of the word in progress, output word and flags.
- bit_valid  input  1  qualifies serial_in; a bit is accepted on every edge where this is 1.
- serial_in  input  1  serial data bit.
- shift_dir  input  1  bit order: 0 = MSB-first, 1 = LSB-first; sampled on the first bit of each word.
- data_out  output  WIDTH  last completed word.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts data_out when out_valid=1 and out_ready=1 on the same edge.
- busy  output  1  a word is partially received (bit_cnt ≠ 0).
- overrun  output  1  sticky; a completed word was dropped.
- parity_err  output  1  sticky parity error; meaningful only with the optional feature.

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset_n is asynchronous, active-low.
  - While reset_n=0: shift_reg=0, bit_cnt=0, dir_lat=0, data_out=0, out_valid=0, busy=0, overrun=0, parity_err=0, state=COLLECT.
- clr (synchronous, priority over every other input except reset): forces the same values as reset on the next edge. Any bit presented in that cycle is discarded.
- Accepting a bit (bit_valid=1):
  - If bit_cnt=0, latch dir_lat ← shift_dir and use it for this bit. Otherwise use the held dir_lat. A shift_dir change mid-word is ignored.
  - dir=0 (MSB-first): shift_reg ← {shift_reg[WIDTH-2:0], serial_in}.
  - dir=1 (LSB-first): shift_reg ← {serial_in, shift_reg[WIDTH-1:1]}.
  - bit_cnt increments. When bit_valid=0, nothing changes; gaps of any length are allowed.
- Word completion (bit accepted with bit_cnt = WIDTH-1):
  - bit_cnt wraps to 0.
  - The assembled word, including the bit accepted on this edge, is the completed word. It is visible on data_out with out_valid=1 right after that edge: zero added latency.
- Output handshake:
  - out_valid stays 1 and data_out stays stable until an edge with out_ready=1, which clears out_valid.
  - Completion on the same edge as a consume: data_out loads the new word and out_valid remains 1.
  - Completion while out_valid=1 and out_ready=0: the new word is dropped, data_out is unchanged, overrun ← 1 (sticky until clr or reset).
- busy = (bit_cnt ≠ 0), driven combinationally from the register.
- State machine:
  - COLLECT only when the optional feature is off.
  - With the feature on: COLLECT → PARITY after WIDTH data bits; PARITY → COLLECT on the next accepted bit.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit. The parity bit is the XOR of the data bits.
  - Completion moves to the edge that accepts the parity bit; the data word is still WIDTH bits.
  - A mismatch sets parity_err (sticky until clr or reset). The word is still delivered.
  - busy = 1 while in the PARITY state.
- Undefined: no PARITY state, and parity_err is tied to 0.

Test Plan:
- WIDTH=4, shift_dir=0, bits 1,0,1,1 on consecutive edges, out_ready=1 → out_valid=1 after the 4th edge, data_out=4'b1011, cleared the following edge.
- shift_dir=1, bits 1,0,1,1 → data_out=4'b1101. Toggling shift_dir after the 1st bit has no effect on the result.
- Bits 1,1,0,0 with bit_valid=0 gaps of 3 cycles between bits → data_out=4'b1100; busy=1 from the 1st to the 4th accepted bit.
- out_ready=0; send 4'b1011 then 4'b0110 back-to-back → data_out stays 4'b1011 and overrun=1. Then out_ready=1 for one edge → out_valid=0 and overrun stays 1 until clr.
- Send 2 bits, pulse reset_n low mid-cycle → outputs go to 0 immediately without a clock edge. Next 4 bits 0,1,1,1 (MSB-first) → data_out=4'b0111.
- With SIPO_PARITY_CHECK_EN, send 1,0,1,1 then parity 1 → data_out=4'b1011, parity_err=0. Send 1,0,1,1 then parity 0 → word delivered, parity_err=1.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with valid/ready word output.
// Optional even-parity frame check: define SIPO_PARITY_CHECK_EN.
module sipo_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             shift_dir,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  typedef enum logic {
    COLLECT,
    PARITY
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] bit_cnt;
  logic             dir_lat;
  logic             dir;
  logic             last;
  logic             in_par;
  logic             word_done;
  logic             par_bad;
  logic             par_q;

  assign dir  = (bit_cnt == '0) ? shift_dir : dir_lat;
  assign last = (bit_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    shift_nxt = {shift_reg[WIDTH-2:0], serial_in};
    if (dir)
      shift_nxt = {serial_in, shift_reg[WIDTH-1:1]};
  end

`ifdef SIPO_PARITY_CHECK_EN
  // The word is already assembled when the parity bit arrives.
  assign in_par     = (state == PARITY);
  assign word_done  = bit_valid && in_par;
  assign word       = shift_reg;
  assign par_bad    = (^shift_reg) != serial_in;
  assign parity_err = par_q;
`else
  assign in_par     = 1'b0;
  assign word_done  = bit_valid && last;
  assign word       = shift_nxt;
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign busy = (bit_cnt != '0) || (state == PARITY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= COLLECT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      dir_lat   <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      par_q     <= 1'b0;
    end else if (clr) begin
      state     <= COLLECT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      dir_lat   <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      if (bit_valid) begin
        if (in_par) begin
          state <= COLLECT;
          if (par_bad)
            par_q <= 1'b1;
        end else begin
          shift_reg <= shift_nxt;
          if (bit_cnt == '0)
            dir_lat <= shift_dir;
          if (last) begin
            bit_cnt <= '0;
`ifdef SIPO_PARITY_CHECK_EN
            state   <= PARITY;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
      // A completion either fills a free/consumed slot or is dropped.
      if (word_done) begin
        if (!out_valid || out_ready) begin
          data_out  <= word;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (WIDTH=4).
// Parity frames are exercised when SIPO_PARITY_CHECK_EN is defined.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr;
  logic       bit_valid;
  logic       serial_in;
  logic       shift_dir;
  logic [3:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  sipo_deserializer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .shift_dir (shift_dir),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    bit_valid = 1'b1;
    serial_in = b;
    shift_dir = d;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_msb(input logic [3:0] w);
    logic [3:0] t;
    t = w;
    for (int i = 3; i >= 0; i--)
      send_bit(t[i], 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    clr       = 1'b0;
    bit_valid = 1'b0;
    serial_in = 1'b0;
    shift_dir = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    reset_n = 1'b1;
    tick();

`ifdef SIPO_PARITY_CHECK_EN
    send_msb(4'b1011);
    chk("p_busy_par", 32'(busy), 32'h1);
    chk("p_valid_pre", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    chk("p_valid", 32'(out_valid), 32'h1);
    chk("p_data", 32'(data_out), 32'hb);
    chk("p_perr_ok", 32'(parity_err), 32'h0);
    chk("p_busy_done", 32'(busy), 32'h0);
    tick();
    chk("p_consumed", 32'(out_valid), 32'h0);
    send_msb(4'b1011);
    send_bit(1'b0, 1'b0);
    chk("p_valid2", 32'(out_valid), 32'h1);
    chk("p_data2", 32'(data_out), 32'hb);
    chk("p_perr_bad", 32'(parity_err), 32'h1);
    tick();
    chk("p_perr_sticky", 32'(parity_err), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("p_perr_clr", 32'(parity_err), 32'h0);
`else
    // MSB-first, immediate consume
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_valid_pre", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(data_out), 32'hb);
    chk("t1_busy_done", 32'(busy), 32'h0);
    tick();
    chk("t1_consumed", 32'(out_valid), 32'h0);

    // LSB-first, shift_dir toggled mid-word
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t2_valid", 32'(out_valid), 32'h1);
    chk("t2_data", 32'(data_out), 32'hd);
    tick();

    // gaps between bits
    send_bit(1'b1, 1'b0);
    repeat (3) tick();
    chk("t3_busy1", 32'(busy), 32'h1);
    send_bit(1'b1, 1'b0);
    repeat (3) tick();
    chk("t3_busy2", 32'(busy), 32'h1);
    send_bit(1'b0, 1'b0);
    repeat (3) tick();
    chk("t3_busy3", 32'(busy), 32'h1);
    chk("t3_valid_pre", 32'(out_valid), 32'h0);
    send_bit(1'b0, 1'b0);
    chk("t3_data", 32'(data_out), 32'hc);
    chk("t3_busy4", 32'(busy), 32'h0);
    tick();

    // overrun
    out_ready = 1'b0;
    send_msb(4'b1011);
    chk("t4_data1", 32'(data_out), 32'hb);
    chk("t4_ovr0", 32'(overrun), 32'h0);
    send_msb(4'b0110);
    chk("t4_data_kept", 32'(data_out), 32'hb);
    chk("t4_ovr1", 32'(overrun), 32'h1);
    chk("t4_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("t4_consumed", 32'(out_valid), 32'h0);
    chk("t4_ovr_sticky", 32'(overrun), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_ovr_clr", 32'(overrun), 32'h0);

    // async reset mid-word
    out_ready = 1'b0;
    send_msb(4'b1101);
    chk("t5_hold", 32'(data_out), 32'hd);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("t5_busy", 32'(busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_data", 32'(data_out), 32'h0);
    chk("t5_async_valid", 32'(out_valid), 32'h0);
    chk("t5_async_busy", 32'(busy), 32'h0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send_msb(4'b0111);
    chk("t5_data", 32'(data_out), 32'h7);
    chk("t5_valid", 32'(out_valid), 32'h1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
